// File: rtl/pipe_ctrl_pkg.sv
// Types shared by the pipeline control logic: FSM states and a stall/flush vector
// ordered from the PC toward writeback.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_REDIR_WAIT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idexe;
        logic exemem;
        logic memwb;
    } pipe_ctl_t;

    localparam pipe_ctl_t PIPE_CTL_NONE = '{default: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EXE.
// Purely combinational; x0 never creates a dependency.
module load_use_detect (
    input  logic       i_valid_exe,
    input  logic       i_is_load_exe,
    input  logic [4:0] i_rd_exe,
    input  logic [4:0] i_rs1_id,
    input  logic [4:0] i_rs2_id,
    input  logic       i_use_rs1_id,
    input  logic       i_use_rs2_id,
    output logic       o_hazard
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_use_rs1_id && (i_rs1_id == i_rd_exe);
    assign w_rs2_hit = i_use_rs2_id && (i_rs2_id == i_rd_exe);
    assign o_hazard  = i_valid_exe && i_is_load_exe && (i_rd_exe != 5'd0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/redirect controller for the 5-stage core, with saturating perf counters.
// Control outputs are combinational from inputs and state; redirects issue in the same cycle.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_imem_busy,
    input  logic             i_dmem_busy,
    input  logic             i_valid_exe,
    input  logic             i_is_load_exe,
    input  logic [4:0]       i_rd_exe,
    input  logic [4:0]       i_rs1_id,
    input  logic [4:0]       i_rs2_id,
    input  logic             i_use_rs1_id,
    input  logic             i_use_rs2_id,
    input  logic             i_mispredict_exe,
    input  logic [XLEN-1:0]  i_target_pc_exe,
    input  logic             i_trap_mem,
    input  logic [XLEN-1:0]  i_trap_pc_mem,
    output logic             o_stall_pc,
    output logic             o_stall_ifid,
    output logic             o_stall_idexe,
    output logic             o_stall_exemem,
    output logic             o_stall_memwb,
    output logic             o_flush_ifid,
    output logic             o_flush_idexe,
    output logic             o_flush_exemem,
    output logic             o_flush_memwb,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_t      r_state;
    logic [XLEN-1:0]  r_pend_pc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    ctrl_state_t      w_next_state;
    logic [XLEN-1:0]  w_pend_nxt;
    logic [XLEN-1:0]  w_evt_pc;
    pipe_ctl_t        w_stall;
    pipe_ctl_t        w_flush;
    logic             w_redir_vld;
    logic [XLEN-1:0]  w_redir_pc;
    logic             w_flush_evt;
    logic             w_load_use;

    load_use_detect u_load_use_detect (
        .i_valid_exe   (i_valid_exe),
        .i_is_load_exe (i_is_load_exe),
        .i_rd_exe      (i_rd_exe),
        .i_rs1_id      (i_rs1_id),
        .i_rs2_id      (i_rs2_id),
        .i_use_rs1_id  (i_use_rs1_id),
        .i_use_rs2_id  (i_use_rs2_id),
        .o_hazard      (w_load_use)
    );

    always_comb begin
        w_next_state = r_state;
        w_pend_nxt   = r_pend_pc;
        w_evt_pc     = i_trap_mem ? i_trap_pc_mem : i_target_pc_exe;
        w_stall      = PIPE_CTL_NONE;
        w_flush      = PIPE_CTL_NONE;
        w_redir_vld  = 1'b0;
        w_redir_pc   = '0;
        w_flush_evt  = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (i_dmem_busy) begin
                        w_stall.pc     = 1'b1;
                        w_stall.ifid   = 1'b1;
                        w_stall.idexe  = 1'b1;
                        w_stall.exemem = 1'b1;
                        w_flush.memwb  = 1'b1;
                    end else if (i_trap_mem || i_mispredict_exe) begin
                        // A trap also squashes EXE; a mispredict lets EXE advance.
                        w_flush.ifid   = 1'b1;
                        w_flush.idexe  = 1'b1;
                        w_flush.exemem = i_trap_mem;
                        w_flush_evt    = 1'b1;
                        if (i_imem_busy) begin
                            w_stall.pc   = 1'b1;
                            w_pend_nxt   = w_evt_pc;
                            w_next_state = ST_REDIR_WAIT;
                        end else begin
                            w_redir_vld = 1'b1;
                            w_redir_pc  = w_evt_pc;
                        end
                    end else if (w_load_use) begin
                        w_stall.pc    = 1'b1;
                        w_stall.ifid  = 1'b1;
                        w_flush.idexe = 1'b1;
                    end else if (i_imem_busy) begin
                        w_stall.pc   = 1'b1;
                        w_flush.ifid = 1'b1;
                    end
                end
                ST_REDIR_WAIT: begin
                    w_stall.pc   = 1'b1;
                    w_flush.ifid = 1'b1;
                    if (i_dmem_busy) begin
                        w_stall.idexe  = 1'b1;
                        w_stall.exemem = 1'b1;
                        w_flush.memwb  = 1'b1;
                    end else if (i_trap_mem) begin
                        w_flush.idexe  = 1'b1;
                        w_flush.exemem = 1'b1;
                        w_flush_evt    = 1'b1;
                        w_pend_nxt     = i_trap_pc_mem;
                    end
                    // The PC must load the redirect target, so its hold is released here.
                    if (!i_imem_busy) begin
                        w_stall.pc   = 1'b0;
                        w_redir_vld  = 1'b1;
                        w_redir_pc   = (i_trap_mem && !i_dmem_busy) ? i_trap_pc_mem : r_pend_pc;
                        w_next_state = ST_RUN;
                    end
                end
                default: w_next_state = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_pend_pc   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pend_pc <= w_pend_nxt;
            if ((|w_stall) && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_flush_evt && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign o_stall_pc       = w_stall.pc;
    assign o_stall_ifid     = w_stall.ifid;
    assign o_stall_idexe    = w_stall.idexe;
    assign o_stall_exemem   = w_stall.exemem;
    assign o_stall_memwb    = w_stall.memwb;
    assign o_flush_ifid     = w_flush.ifid;
    assign o_flush_idexe    = w_flush.idexe;
    assign o_flush_exemem   = w_flush.exemem;
    assign o_flush_memwb    = w_flush.memwb;
    assign o_redirect_valid = w_redir_vld;
    assign o_redirect_pc    = w_redir_pc;
    assign o_stall_cnt      = r_stall_cnt;
    assign o_flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector table for single-cycle priority cases plus hand-written multi-cycle
// sequences for redirect waits, dmem holds, reset and counter saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_busy, dmem_busy, valid_exe, is_load_exe;
    logic [4:0]  rd_exe, rs1_id, rs2_id;
    logic        use_rs1_id, use_rs2_id;
    logic        mispredict_exe, trap_mem;
    logic [63:0] target_pc_exe, trap_pc_mem;

    logic        stall_pc, stall_ifid, stall_idexe, stall_exemem, stall_memwb;
    logic        flush_ifid, flush_idexe, flush_exemem, flush_memwb;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_stall_pc, s_stall_ifid, s_stall_idexe, s_stall_exemem, s_stall_memwb;
    logic        s_flush_ifid, s_flush_idexe, s_flush_exemem, s_flush_memwb;
    logic        s_redirect_valid;
    logic [63:0] s_redirect_pc;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_imem_busy(imem_busy), .i_dmem_busy(dmem_busy),
        .i_valid_exe(valid_exe), .i_is_load_exe(is_load_exe), .i_rd_exe(rd_exe),
        .i_rs1_id(rs1_id), .i_rs2_id(rs2_id), .i_use_rs1_id(use_rs1_id), .i_use_rs2_id(use_rs2_id),
        .i_mispredict_exe(mispredict_exe), .i_target_pc_exe(target_pc_exe),
        .i_trap_mem(trap_mem), .i_trap_pc_mem(trap_pc_mem),
        .o_stall_pc(stall_pc), .o_stall_ifid(stall_ifid), .o_stall_idexe(stall_idexe),
        .o_stall_exemem(stall_exemem), .o_stall_memwb(stall_memwb),
        .o_flush_ifid(flush_ifid), .o_flush_idexe(flush_idexe),
        .o_flush_exemem(flush_exemem), .o_flush_memwb(flush_memwb),
        .o_redirect_valid(redirect_valid), .o_redirect_pc(redirect_pc),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.XLEN(64), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .i_imem_busy(imem_busy), .i_dmem_busy(dmem_busy),
        .i_valid_exe(valid_exe), .i_is_load_exe(is_load_exe), .i_rd_exe(rd_exe),
        .i_rs1_id(rs1_id), .i_rs2_id(rs2_id), .i_use_rs1_id(use_rs1_id), .i_use_rs2_id(use_rs2_id),
        .i_mispredict_exe(mispredict_exe), .i_target_pc_exe(target_pc_exe),
        .i_trap_mem(trap_mem), .i_trap_pc_mem(trap_pc_mem),
        .o_stall_pc(s_stall_pc), .o_stall_ifid(s_stall_ifid), .o_stall_idexe(s_stall_idexe),
        .o_stall_exemem(s_stall_exemem), .o_stall_memwb(s_stall_memwb),
        .o_flush_ifid(s_flush_ifid), .o_flush_idexe(s_flush_idexe),
        .o_flush_exemem(s_flush_exemem), .o_flush_memwb(s_flush_memwb),
        .o_redirect_valid(s_redirect_valid), .o_redirect_pc(s_redirect_pc),
        .o_stall_cnt(s_stall_cnt), .o_flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        imem, dmem, vexe, ld;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, mp;
        logic [63:0] tgt;
        logic        trap;
        logic [63:0] tpc;
        logic [4:0]  st, fl;
        logic        rv;
        logic [63:0] rpc;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [4:0] st, input logic [4:0] fl,
                              input logic rv, input logic [63:0] rpc);
        chk({tag, " stall"}, {59'd0, stall_pc, stall_ifid, stall_idexe, stall_exemem, stall_memwb}, {59'd0, st});
        chk({tag, " flush"}, {59'd0, 1'b0, flush_ifid, flush_idexe, flush_exemem, flush_memwb}, {59'd0, fl});
        chk({tag, " redir_vld"}, {63'd0, redirect_valid}, {63'd0, rv});
        if (rv) chk({tag, " redir_pc"}, redirect_pc, rpc);
    endtask

    task automatic idle();
        imem_busy = 0; dmem_busy = 0; valid_exe = 0; is_load_exe = 0;
        rd_exe = 0; rs1_id = 0; rs2_id = 0; use_rs1_id = 0; use_rs2_id = 0;
        mispredict_exe = 0; target_pc_exe = 0; trap_mem = 0; trap_pc_mem = 0;
    endtask

    task automatic set_ev(input logic im, input logic dm, input logic mp, input logic [63:0] tgt,
                          input logic tr, input logic [63:0] tpc);
        idle();
        imem_busy = im; dmem_busy = dm; mispredict_exe = mp; target_pc_exe = tgt;
        trap_mem = tr; trap_pc_mem = tpc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // imem dmem vexe ld rd rs1 rs2 u1 u2 mp tgt trap tpc | stall flush rv rpc
        vt[0]  = '{0,0,0,0,5'd0,5'd0,5'd0,0,0,0,64'h0,0,64'h0, 5'b00000,5'b00000,0,64'h0};
        vt[1]  = '{0,0,1,1,5'd5,5'd1,5'd5,0,1,0,64'h0,0,64'h0, 5'b11000,5'b00100,0,64'h0};
        vt[2]  = '{0,0,1,1,5'd0,5'd1,5'd0,0,1,0,64'h0,0,64'h0, 5'b00000,5'b00000,0,64'h0};
        vt[3]  = '{0,0,1,1,5'd5,5'd5,5'd7,1,0,0,64'h0,0,64'h0, 5'b11000,5'b00100,0,64'h0};
        vt[4]  = '{0,0,1,1,5'd5,5'd5,5'd7,0,1,0,64'h0,0,64'h0, 5'b00000,5'b00000,0,64'h0};
        vt[5]  = '{0,0,1,0,5'd5,5'd5,5'd5,1,1,0,64'h0,0,64'h0, 5'b00000,5'b00000,0,64'h0};
        vt[6]  = '{0,0,0,1,5'd5,5'd5,5'd5,1,1,0,64'h0,0,64'h0, 5'b00000,5'b00000,0,64'h0};
        vt[7]  = '{0,0,0,0,5'd0,5'd0,5'd0,0,0,1,64'h8000_0100,0,64'h0, 5'b00000,5'b01100,1,64'h8000_0100};
        vt[8]  = '{0,0,0,0,5'd0,5'd0,5'd0,0,0,1,64'h300,1,64'h1000, 5'b00000,5'b01110,1,64'h1000};
        vt[9]  = '{0,1,0,0,5'd0,5'd0,5'd0,0,0,0,64'h0,1,64'h1000, 5'b11110,5'b00001,0,64'h0};
        vt[10] = '{1,0,0,0,5'd0,5'd0,5'd0,0,0,0,64'h0,0,64'h0, 5'b10000,5'b01000,0,64'h0};
        vt[11] = '{1,0,1,1,5'd5,5'd5,5'd0,1,0,0,64'h0,0,64'h0, 5'b11000,5'b00100,0,64'h0};
        vt[12] = '{0,1,1,1,5'd5,5'd5,5'd0,1,0,0,64'h0,0,64'h0, 5'b11110,5'b00001,0,64'h0};
        vt[13] = '{0,0,1,1,5'd5,5'd5,5'd0,1,0,1,64'h40,0,64'h0, 5'b00000,5'b01100,1,64'h40};

        // Reset with hazards present: nothing may be driven.
        rst = 1;
        set_ev(1, 0, 1, 64'h300, 1, 64'h1000);
        next_cycle();
        @(negedge clk);
        expect_out("reset", 5'b00000, 5'b00000, 0, 64'h0);
        chk("reset stall_cnt", {32'd0, stall_cnt}, 64'd0);
        chk("reset flush_cnt", {32'd0, flush_cnt}, 64'd0);
        next_cycle();
        rst = 0;
        idle();

        for (int i = 0; i < 14; i++) begin
            next_cycle();
            imem_busy = vt[i].imem; dmem_busy = vt[i].dmem; valid_exe = vt[i].vexe;
            is_load_exe = vt[i].ld; rd_exe = vt[i].rd; rs1_id = vt[i].rs1; rs2_id = vt[i].rs2;
            use_rs1_id = vt[i].u1; use_rs2_id = vt[i].u2; mispredict_exe = vt[i].mp;
            target_pc_exe = vt[i].tgt; trap_mem = vt[i].trap; trap_pc_mem = vt[i].tpc;
            @(negedge clk);
            expect_out($sformatf("vec%0d", i), vt[i].st, vt[i].fl, vt[i].rv, vt[i].rpc);
        end
        next_cycle();
        idle();
        @(negedge clk);
        chk("table stall_cnt", {32'd0, stall_cnt}, 64'd6);
        chk("table flush_cnt", {32'd0, flush_cnt}, 64'd3);

        // Mispredict while imem busy for 3 cycles, redirect when it drops.
        next_cycle(); set_ev(1, 0, 1, 64'h200, 0, 64'h0);
        @(negedge clk); expect_out("mpwait c0", 5'b10000, 5'b01100, 0, 64'h0);
        for (int c = 1; c < 3; c++) begin
            next_cycle(); set_ev(1, 0, 0, 64'h0, 0, 64'h0);
            @(negedge clk); expect_out($sformatf("mpwait c%0d", c), 5'b10000, 5'b01000, 0, 64'h0);
        end
        next_cycle(); set_ev(0, 0, 0, 64'h0, 0, 64'h0);
        @(negedge clk);
        chk("mpwait redir_vld", {63'd0, redirect_valid}, 64'd1);
        chk("mpwait redir_pc", redirect_pc, 64'h200);
        chk("mpwait flush_ifid", {63'd0, flush_ifid}, 64'd1);
        next_cycle(); idle();
        @(negedge clk); expect_out("mpwait after", 5'b00000, 5'b00000, 0, 64'h0);

        // Trap held behind dmem_busy for 2 cycles.
        for (int c = 0; c < 2; c++) begin
            next_cycle(); set_ev(0, 1, 0, 64'h0, 1, 64'h1000);
            @(negedge clk); expect_out($sformatf("trapdm c%0d", c), 5'b11110, 5'b00001, 0, 64'h0);
        end
        next_cycle(); set_ev(0, 0, 0, 64'h0, 1, 64'h1000);
        @(negedge clk); expect_out("trapdm go", 5'b00000, 5'b01110, 1, 64'h1000);

        // Trap arriving in REDIR_WAIT overwrites the pending mispredict target.
        next_cycle(); set_ev(1, 0, 1, 64'h300, 0, 64'h0);
        @(negedge clk); expect_out("ovr c0", 5'b10000, 5'b01100, 0, 64'h0);
        next_cycle(); set_ev(1, 0, 0, 64'h0, 1, 64'h1000);
        @(negedge clk); expect_out("ovr c1", 5'b10000, 5'b01110, 0, 64'h0);
        next_cycle(); set_ev(0, 0, 0, 64'h0, 0, 64'h0);
        @(negedge clk);
        chk("ovr redir_vld", {63'd0, redirect_valid}, 64'd1);
        chk("ovr redir_pc", redirect_pc, 64'h1000);

        // Trap in REDIR_WAIT on the cycle imem drops redirects straight to it.
        next_cycle(); set_ev(1, 0, 1, 64'h300, 0, 64'h0);
        @(negedge clk); expect_out("direct c0", 5'b10000, 5'b01100, 0, 64'h0);
        next_cycle(); set_ev(0, 0, 0, 64'h0, 1, 64'h2000);
        @(negedge clk);
        chk("direct redir_vld", {63'd0, redirect_valid}, 64'd1);
        chk("direct redir_pc", redirect_pc, 64'h2000);
        chk("direct flush_exemem", {63'd0, flush_exemem}, 64'd1);
        next_cycle(); idle();
        @(negedge clk); expect_out("direct after", 5'b00000, 5'b00000, 0, 64'h0);

        // dmem_busy in REDIR_WAIT: downstream held, trap ignored, pending PC kept.
        next_cycle(); set_ev(1, 0, 1, 64'h400, 0, 64'h0);
        @(negedge clk); expect_out("wdm c0", 5'b10000, 5'b01100, 0, 64'h0);
        next_cycle(); set_ev(1, 1, 0, 64'h0, 1, 64'h5000);
        @(negedge clk); expect_out("wdm c1", 5'b10110, 5'b01001, 0, 64'h0);
        next_cycle(); set_ev(0, 0, 0, 64'h0, 0, 64'h0);
        @(negedge clk);
        chk("wdm redir_vld", {63'd0, redirect_valid}, 64'd1);
        chk("wdm redir_pc", redirect_pc, 64'h400);
        next_cycle(); idle();
        @(negedge clk);
        chk("seq flush_cnt", {32'd0, flush_cnt}, 64'd10);

        // Reset while waiting discards the pending redirect.
        next_cycle(); set_ev(1, 0, 1, 64'h500, 0, 64'h0);
        next_cycle(); rst = 1; set_ev(0, 0, 0, 64'h0, 0, 64'h0);
        @(negedge clk); expect_out("rstwait in", 5'b00000, 5'b00000, 0, 64'h0);
        next_cycle(); rst = 0; idle();
        @(negedge clk);
        expect_out("rstwait out", 5'b00000, 5'b00000, 0, 64'h0);
        chk("rstwait stall_cnt", {32'd0, stall_cnt}, 64'd0);
        chk("rstwait flush_cnt", {32'd0, flush_cnt}, 64'd0);

        // 20 stall cycles: the 4-bit counter must stick at all-ones.
        for (int c = 0; c < 20; c++) begin
            next_cycle(); set_ev(1, 0, 0, 64'h0, 0, 64'h0);
        end
        next_cycle(); idle();
        @(negedge clk);
        chk("sat wide stall_cnt", {32'd0, stall_cnt}, 64'd20);
        chk("sat narrow stall_cnt", {60'd0, s_stall_cnt}, 64'hF);
        chk("sat narrow flush_cnt", {60'd0, s_flush_cnt}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
